// File: rtl/cargador_instrucciones_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The slave modport is the loader's view; the master modport is the source/memory side.
interface cargador_instrucciones_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cargador_instrucciones.sv
// Program loader: assembles big-endian 32-bit words from a byte stream and writes
// them to instruction memory at stride 4 while holding the datapath stalled.
module cargador_instrucciones #(
    parameter logic [7:0]  BASE_ADDR = 8'h00,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic                           clkGeneral,
    input  logic                           rst_n,
    input  logic                           start,
    cargador_instrucciones_if.slave        bus,
    output logic                           cpu_hold,
    output logic                           done,
    output logic                           error,
    output logic [6:0]                     word_count
);

    localparam int unsigned CNT_W  = 7;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              byte_ready_q, byte_ready_d;
    logic              mem_we_q, mem_we_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              handshake;

    assign handshake = bus.byte_valid & byte_ready_q;

    // Next-state, datapath update, and Moore outputs decoded from the next state
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        last_d  = last_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    addr_d  = BASE_ADDR;
                    state_d = S_RECV;
                end
            end
            S_RECV: begin
                if (handshake) begin
                    shift_d = {shift_q[23:0], bus.byte_data};
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        last_d  = bus.byte_last;
                        state_d = S_WRITE;
                    end else if (bus.byte_last) begin
                        // Program ended mid-word: drop the fragment
                        state_d = S_ERR;
                    end
                end
            end
            S_WRITE: begin
                addr_d = addr_q + ADDR_W'(4);
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_q) begin
                    state_d = S_DONE;
                end else if (cnt_d == CNT_W'(MAX_WORDS)) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        byte_ready_d = (state_d == S_RECV);
        mem_we_d     = (state_d == S_WRITE);
        cpu_hold_d   = (state_d != S_IDLE);
        done_d       = (state_d == S_DONE);
        error_d      = (state_d == S_ERR);
    end

    always_ff @(posedge clkGeneral or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= 2'd0;
            shift_q      <= '0;
            last_q       <= 1'b0;
            addr_q       <= BASE_ADDR;
            cnt_q        <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            last_q       <= last_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = shift_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = cnt_q;

endmodule

// File: tb/tb_cargador_instrucciones.sv
// Self-checking bench for cargador_instrucciones: scoreboarded memory writes,
// handshake timing, partial-word error, address wrap/overflow, and mid-session reset.
module tb_cargador_instrucciones;

    logic clkGeneral = 1'b0;
    logic rst_n      = 1'b0;
    logic start_a    = 1'b0;
    logic start_b    = 1'b0;

    always #5 clkGeneral = ~clkGeneral;

    cargador_instrucciones_if a_if ();
    cargador_instrucciones_if b_if ();

    logic       hold_a, done_a, err_a, hold_b, done_b, err_b;
    logic [6:0] wc_a, wc_b;

    cargador_instrucciones #(.BASE_ADDR(8'h00), .MAX_WORDS(64)) u_dut_a (
        .clkGeneral (clkGeneral),
        .rst_n      (rst_n),
        .start      (start_a),
        .bus        (a_if),
        .cpu_hold   (hold_a),
        .done       (done_a),
        .error      (err_a),
        .word_count (wc_a)
    );

    cargador_instrucciones #(.BASE_ADDR(8'hF8), .MAX_WORDS(64)) u_dut_b (
        .clkGeneral (clkGeneral),
        .rst_n      (rst_n),
        .start      (start_b),
        .bus        (b_if),
        .cpu_hold   (hold_b),
        .done       (done_b),
        .error      (err_b),
        .word_count (wc_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [39:0] q_a[$];
    logic [39:0] q_b[$];
    logic [7:0]  exp_addr_a, exp_addr_b;
    logic [31:0] mem_a [256];

    // Write monitors: pop expected {addr,data}, and byte_ready must be low while writing
    always @(negedge clkGeneral) begin
        if (a_if.mem_we === 1'b1) begin
            logic [39:0] e;
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL write_a unexpected: got addr=%h data=%h, none expected", a_if.mem_addr, a_if.mem_wdata);
            end else begin
                e = q_a.pop_front();
                if ({a_if.mem_addr, a_if.mem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write_a: got addr=%h data=%h, expected addr=%h data=%h", a_if.mem_addr, a_if.mem_wdata, e[39:32], e[31:0]);
                end
            end
            n_checks++;
            if (a_if.byte_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_in_write_a: got %b expected 0", a_if.byte_ready);
            end
            mem_a[a_if.mem_addr] = a_if.mem_wdata;
        end
    end

    always @(negedge clkGeneral) begin
        if (b_if.mem_we === 1'b1) begin
            logic [39:0] e;
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL write_b unexpected: got addr=%h data=%h, none expected", b_if.mem_addr, b_if.mem_wdata);
            end else begin
                e = q_b.pop_front();
                if ({b_if.mem_addr, b_if.mem_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL write_b: got addr=%h data=%h, expected addr=%h data=%h", b_if.mem_addr, b_if.mem_wdata, e[39:32], e[31:0]);
                end
            end
            n_checks++;
            if (b_if.byte_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_in_write_b: got %b expected 0", b_if.byte_ready);
            end
        end
    end

    task automatic drop_valid(input bit sel);
        if (sel) b_if.byte_valid = 1'b0;
        else     a_if.byte_valid = 1'b0;
    endtask

    // Present a byte at a falling edge; it is taken at the next rising edge iff ready was high
    task automatic send_byte(input bit sel, input logic [7:0] d, input logic last);
        bit ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            logic r;
            @(negedge clkGeneral);
            if (sel) begin
                b_if.byte_valid = 1'b1; b_if.byte_data = d; b_if.byte_last = last; r = b_if.byte_ready;
            end else begin
                a_if.byte_valid = 1'b1; a_if.byte_data = d; a_if.byte_last = last; r = a_if.byte_ready;
            end
            @(posedge clkGeneral);
            #1;
            if (r === 1'b1) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL handshake_timeout sel=%0d: byte %h never accepted", sel, d);
        end
    endtask

    task automatic send_word(input bit sel, input logic [31:0] w, input bit last, input int gap_max);
        for (int i = 0; i < 4; i++) begin
            if (gap_max > 0) begin
                int g = $urandom_range(0, gap_max);
                if (g > 0) begin
                    drop_valid(sel);
                    repeat (g) @(posedge clkGeneral);
                end
            end
            if (i == 3) begin
                if (sel) begin q_b.push_back({exp_addr_b, w}); exp_addr_b = exp_addr_b + 8'd4; end
                else     begin q_a.push_back({exp_addr_a, w}); exp_addr_a = exp_addr_a + 8'd4; end
            end
            send_byte(sel, w[31-8*i -: 8], last && (i == 3));
        end
    endtask

    task automatic pulse_start(input bit sel);
        @(negedge clkGeneral);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clkGeneral);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done_a(input string name);
        bit seen = 1'b0;
        for (int t = 0; t < 60 && !seen; t++) begin
            @(negedge clkGeneral);
            if (done_a === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL %s done_timeout: done never pulsed", name); end
    endtask

    task automatic test_reset();
        @(negedge clkGeneral);
        n_checks++;
        if ({a_if.byte_ready, a_if.mem_we, hold_a, done_a, err_a} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags_a: got %b expected 00000", {a_if.byte_ready, a_if.mem_we, hold_a, done_a, err_a});
        end
        n_checks++;
        if (a_if.mem_addr !== 8'h00 || a_if.mem_wdata !== 32'h0 || wc_a !== 7'd0) begin
            n_fail++; $display("FAIL reset_data_a: got addr=%h data=%h wc=%0d expected 00/0/0", a_if.mem_addr, a_if.mem_wdata, wc_a);
        end
        n_checks++;
        if (b_if.mem_addr !== 8'hF8 || hold_b !== 1'b0 || err_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_b: got addr=%h hold=%b err=%b expected F8/0/0", b_if.mem_addr, hold_b, err_b);
        end
        rst_n = 1'b1;
        @(posedge clkGeneral);
        #1;
    endtask

    task automatic test_basic_load();
        pulse_start(1'b0);
        exp_addr_a = 8'h00;
        n_checks++;
        if (hold_a !== 1'b1 || a_if.byte_ready !== 1'b1) begin
            n_fail++; $display("FAIL start_latency: got hold=%b ready=%b expected 1/1", hold_a, a_if.byte_ready);
        end
        send_word(1'b0, 32'h20080005, 1'b0, 0);
        send_word(1'b0, 32'h00854820, 1'b1, 0);
        drop_valid(1'b0);
        @(negedge clkGeneral);
        n_checks++;
        if (a_if.mem_we !== 1'b1 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL final_write_cycle: got we=%b done=%b expected 1/0", a_if.mem_we, done_a);
        end
        @(negedge clkGeneral);
        n_checks++;
        if (done_a !== 1'b1 || hold_a !== 1'b1) begin
            n_fail++; $display("FAIL done_pulse: got done=%b hold=%b expected 1/1", done_a, hold_a);
        end
        @(negedge clkGeneral);
        n_checks++;
        if (done_a !== 1'b0 || hold_a !== 1'b0 || wc_a !== 7'd2) begin
            n_fail++; $display("FAIL after_done: got done=%b hold=%b wc=%0d expected 0/0/2", done_a, hold_a, wc_a);
        end
        n_checks++;
        if (q_a.size() != 0) begin n_fail++; $display("FAIL basic_pending: got %0d outstanding writes expected 0", q_a.size()); end
    endtask

    task automatic test_back_to_back();
        pulse_start(1'b0);
        exp_addr_a = 8'h00;
        send_word(1'b0, 32'h20080005, 1'b0, 2);
        send_word(1'b0, 32'h00854820, 1'b0, 2);
        send_word(1'b0, 32'hAC0A0004, 1'b1, 2);
        drop_valid(1'b0);
        wait_done_a("back_to_back");
        @(negedge clkGeneral);
        n_checks++;
        if (wc_a !== 7'd3 || hold_a !== 1'b0 || q_a.size() != 0) begin
            n_fail++; $display("FAIL back_to_back_end: got wc=%0d hold=%b pending=%0d expected 3/0/0", wc_a, hold_a, q_a.size());
        end
    endtask

    task automatic test_partial_word();
        pulse_start(1'b0);
        exp_addr_a = 8'h00;
        send_word(1'b0, 32'h11223344, 1'b0, 0);
        send_byte(1'b0, 8'h55, 1'b0);
        send_byte(1'b0, 8'h66, 1'b1);
        drop_valid(1'b0);
        @(negedge clkGeneral);
        n_checks++;
        if (err_a !== 1'b1 || hold_a !== 1'b1 || a_if.byte_ready !== 1'b0 || wc_a !== 7'd1) begin
            n_fail++; $display("FAIL partial_err: got err=%b hold=%b ready=%b wc=%0d expected 1/1/0/1", err_a, hold_a, a_if.byte_ready, wc_a);
        end
        repeat (3) @(negedge clkGeneral);
        n_checks++;
        if (err_a !== 1'b1 || hold_a !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got err=%b hold=%b expected 1/1", err_a, hold_a);
        end
        pulse_start(1'b0);
        exp_addr_a = 8'h00;
        n_checks++;
        if (err_a !== 1'b0 || a_if.byte_ready !== 1'b1 || wc_a !== 7'd0) begin
            n_fail++; $display("FAIL restart_clear: got err=%b ready=%b wc=%0d expected 0/1/0", err_a, a_if.byte_ready, wc_a);
        end
        send_word(1'b0, 32'hDEADBEEF, 1'b1, 0);
        drop_valid(1'b0);
        wait_done_a("partial_restart");
    endtask

    task automatic test_start_in_recv();
        pulse_start(1'b0);
        exp_addr_a = 8'h00;
        send_byte(1'b0, 8'hCA, 1'b0);
        send_byte(1'b0, 8'hFE, 1'b0);
        drop_valid(1'b0);
        pulse_start(1'b0);
        n_checks++;
        if (hold_a !== 1'b1 || a_if.byte_ready !== 1'b1 || a_if.mem_addr !== 8'h00) begin
            n_fail++; $display("FAIL start_ignored: got hold=%b ready=%b addr=%h expected 1/1/00", hold_a, a_if.byte_ready, a_if.mem_addr);
        end
        q_a.push_back({exp_addr_a, 32'hCAFEF00D});
        exp_addr_a = exp_addr_a + 8'd4;
        send_byte(1'b0, 8'hF0, 1'b0);
        send_byte(1'b0, 8'h0D, 1'b1);
        drop_valid(1'b0);
        wait_done_a("start_in_recv");
        n_checks++;
        if (wc_a !== 7'd1) begin n_fail++; $display("FAIL start_in_recv_count: got wc=%0d expected 1", wc_a); end
    endtask

    task automatic test_reset_mid_session();
        pulse_start(1'b0);
        exp_addr_a = 8'h00;
        send_word(1'b0, 32'h8C220010, 1'b0, 0);
        send_byte(1'b0, 8'hAA, 1'b0);
        send_byte(1'b0, 8'hBB, 1'b0);
        drop_valid(1'b0);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({a_if.byte_ready, a_if.mem_we, hold_a, done_a, err_a} !== 5'b0 || a_if.mem_addr !== 8'h00
            || a_if.mem_wdata !== 32'h0 || wc_a !== 7'd0) begin
            n_fail++; $display("FAIL mid_reset: got flags=%b addr=%h data=%h wc=%0d expected 00000/00/0/0",
                {a_if.byte_ready, a_if.mem_we, hold_a, done_a, err_a}, a_if.mem_addr, a_if.mem_wdata, wc_a);
        end
        n_checks++;
        if (mem_a[0] !== 32'h8C220010 || q_a.size() != 0) begin
            n_fail++; $display("FAIL first_word_kept: got mem[0]=%h pending=%0d expected 8c220010/0", mem_a[0], q_a.size());
        end
        @(negedge clkGeneral);
        rst_n = 1'b1;
        pulse_start(1'b0);
        exp_addr_a = 8'h00;
        send_word(1'b0, 32'h01234567, 1'b1, 0);
        drop_valid(1'b0);
        wait_done_a("post_reset");
    endtask

    task automatic test_wrap_overflow();
        pulse_start(1'b1);
        exp_addr_b = 8'hF8;
        for (int w = 0; w < 64; w++) send_word(1'b1, $urandom, 1'b0, 1);
        drop_valid(1'b1);
        @(negedge clkGeneral);
        @(negedge clkGeneral);
        n_checks++;
        if (err_b !== 1'b1 || wc_b !== 7'd64 || hold_b !== 1'b1 || b_if.byte_ready !== 1'b0) begin
            n_fail++; $display("FAIL overflow: got err=%b wc=%0d hold=%b ready=%b expected 1/64/1/0", err_b, wc_b, hold_b, b_if.byte_ready);
        end
        n_checks++;
        if (q_b.size() != 0) begin n_fail++; $display("FAIL wrap_pending: got %0d outstanding writes expected 0", q_b.size()); end
    endtask

    initial begin
        a_if.byte_valid = 1'b0; a_if.byte_data = 8'h00; a_if.byte_last = 1'b0;
        b_if.byte_valid = 1'b0; b_if.byte_data = 8'h00; b_if.byte_last = 1'b0;
        exp_addr_a = 8'h00;
        exp_addr_b = 8'hF8;
        test_reset();
        test_basic_load();
        test_back_to_back();
        test_partial_word();
        test_start_in_recv();
        test_reset_mid_session();
        test_wrap_overflow();
        repeat (2) @(negedge clkGeneral);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
